// File: rtl/alu_pkg.sv
// Shared ALU datapath types: result flags and the operand-chunking legality check.
package alu_pkg;

  typedef struct packed {
    logic cout;
    logic ovf;
    logic zero;
  } alu_flags_t;

  function automatic bit chunking_ok(input int unsigned width, input int unsigned chunk);
    return (chunk >= 1) && (width >= chunk) && ((width % chunk) == 0);
  endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit ripple adder built from full_adder cells.
module chunk_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);

  logic [CHUNK:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (carry[i]),
      .sum  (sum[i]),
      .cout (carry[i+1])
    );
  end

  assign cout = carry[CHUNK];

endmodule

// File: rtl/full_adder.sv
// One-bit full adder, the leaf cell of the ripple segments.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined adder/subtractor: one CHUNK-bit ripple segment per stage, carry registered
// between stages, valid/ready handshake with a single global advance.
module pipelined_addsub
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int STAGES = (CHUNK >= 1) ? (WIDTH / CHUNK) : 1;

  if (!chunking_ok(WIDTH, CHUNK)) begin : g_bad_cfg
    $error("pipelined_addsub: WIDTH must be a non-zero multiple of CHUNK");
  end

  logic adv;

  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  // Stage g keeps only the operand chunks still to be added and the sum chunks
  // already produced, so register widths shrink/grow along the pipe.
  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    localparam int REM  = WIDTH - g * CHUNK;
    localparam int DONE = (g + 1) * CHUNK;

    logic [REM-1:0]   a_in;
    logic [REM-1:0]   bx_in;
    logic             c_in;
    logic             v_in;
    logic [DONE-1:0]  s_nxt;
    logic [CHUNK-1:0] ch_sum;
    logic             ch_co;
    logic             v_q, v_d;
    logic [DONE-1:0]  s_q, s_d;

    if (g == 0) begin : g_head
      assign a_in  = a;
      assign bx_in = sub ? ~b : b;
      assign c_in  = sub ^ cin;
      assign v_in  = in_valid;
      assign s_nxt = ch_sum;
    end else begin : g_body
      assign a_in  = g_stage[g-1].g_pass.a_q;
      assign bx_in = g_stage[g-1].g_pass.bx_q;
      assign c_in  = g_stage[g-1].g_pass.c_q;
      assign v_in  = g_stage[g-1].v_q;
      assign s_nxt = {ch_sum, g_stage[g-1].s_q};
    end

    chunk_adder #(.CHUNK(CHUNK)) u_chunk (
      .a    (a_in[CHUNK-1:0]),
      .b    (bx_in[CHUNK-1:0]),
      .cin  (c_in),
      .sum  (ch_sum),
      .cout (ch_co)
    );

    always_comb begin
      v_d = v_q;
      s_d = s_q;
      if (adv) begin
        v_d = v_in;
        if (v_in) s_d = s_nxt;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        s_q <= '0;
      end else begin
        v_q <= v_d;
        s_q <= s_d;
      end
    end

    if (g < STAGES - 1) begin : g_pass
      logic [REM-CHUNK-1:0] a_q, a_d;
      logic [REM-CHUNK-1:0] bx_q, bx_d;
      logic                 c_q, c_d;

      always_comb begin
        a_d  = a_q;
        bx_d = bx_q;
        c_d  = c_q;
        if (adv && v_in) begin
          a_d  = a_in[REM-1:CHUNK];
          bx_d = bx_in[REM-1:CHUNK];
          c_d  = ch_co;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q  <= '0;
          bx_q <= '0;
          c_q  <= 1'b0;
        end else begin
          a_q  <= a_d;
          bx_q <= bx_d;
          c_q  <= c_d;
        end
      end
    end else begin : g_tail
      alu_flags_t flags_q, flags_d;

      always_comb begin
        flags_d = flags_q;
        if (adv && v_in) begin
          flags_d.cout = ch_co;
          flags_d.ovf  = (a_in[REM-1] == bx_in[REM-1]) && (s_nxt[WIDTH-1] != a_in[REM-1]);
          flags_d.zero = ~|s_nxt;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) flags_q <= '0;
        else        flags_q <= flags_d;
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].v_q;
  assign sum       = g_stage[STAGES-1].s_q;
  assign cout      = g_stage[STAGES-1].g_tail.flags_q.cout;
  assign ovf       = g_stage[STAGES-1].g_tail.flags_q.ovf;
  assign zero      = g_stage[STAGES-1].g_tail.flags_q.zero;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub: directed corner cases, randomized stream with
// backpressure, mid-flight reset, and the single-stage configuration.
module tb_pipelined_addsub;

  localparam int W  = 16;
  localparam int ST = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] a, b, sum;
  logic         cin, sub, cout, ovf, zero;

  logic         in_valid8, in_ready8, out_valid8, out_ready8;
  logic [7:0]   a8, b8, sum8;
  logic         cin8, sub8, cout8, ovf8, zero8;

  always #5 clk = ~clk;

  pipelined_addsub #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
  );

  pipelined_addsub #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .cin(cin8), .sub(sub8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .sum(sum8), .cout(cout8), .ovf(ovf8), .zero(zero8)
  );

  typedef struct {
    bit           v;
    logic [W-1:0] s;
    logic         co;
    logic         ov;
    logic         z;
  } exp_t;

  exp_t pipe [ST];
  int   passed = 0;
  int   total  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed = passed + 1;
    else $error("FAIL %s: observed %h expected %h", tag, got, exp);
  endtask

  // Reference result from plain integer arithmetic on the operands.
  function automatic exp_t ref_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                                  input logic icin, input logic isub);
    exp_t   r;
    longint ua, ub, sa, sb, ci, u, s;
    ua = longint'(ia);
    ub = longint'(ib);
    sa = longint'($signed(ia));
    sb = longint'($signed(ib));
    ci = longint'(icin);
    if (isub) begin
      u    = ua - ub - ci;
      s    = sa - sb - ci;
      r.co = (u >= 0);
    end else begin
      u    = ua + ub + ci;
      s    = sa + sb + ci;
      r.co = (u >= 65536);
    end
    r.s  = u[W-1:0];
    r.ov = (s > 32767) || (s < -32768);
    r.z  = (r.s == '0);
    r.v  = 1'b1;
    return r;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < ST; i++) pipe[i].v = 1'b0;
  endtask

  // One cycle: drive at the falling edge, check, update model, cross the rising edge.
  task automatic step(input logic iv, input logic [W-1:0] ia, input logic [W-1:0] ib,
                      input logic icin, input logic isub, input logic ordy);
    in_valid  = iv;
    a         = ia;
    b         = ib;
    cin       = icin;
    sub       = isub;
    out_ready = ordy;
    #1;
    check("in_ready", in_ready, !(pipe[ST-1].v && !ordy));
    check("out_valid", out_valid, pipe[ST-1].v);
    if (pipe[ST-1].v) begin
      check("sum", sum, pipe[ST-1].s);
      check("flags", {cout, ovf, zero}, {pipe[ST-1].co, pipe[ST-1].ov, pipe[ST-1].z});
    end
    if (!pipe[ST-1].v || ordy) begin
      for (int i = ST - 1; i > 0; i--) pipe[i] = pipe[i-1];
      pipe[0].v = 1'b0;
      if (iv) pipe[0] = ref_op(ia, ib, icin, isub);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic ordy);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, 1'b0, ordy);
  endtask

  initial begin
    int          acc;
    int          cyc;
    logic        ordy;
    logic        iv;
    logic [W-1:0] ra, rb;

    rst_n      = 1'b0;
    in_valid   = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    in_valid8  = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0; out_ready8 = 1'b1;
    clear_model();
    @(negedge clk);
    @(negedge clk);

    check("rst_out_valid", out_valid, 1'b0);
    check("rst_sum", sum, 16'h0000);
    check("rst_flags", {cout, ovf, zero}, 3'b000);
    check("rst_in_ready", in_ready, 1'b1);
    rst_n = 1'b1;
    @(negedge clk);

    // Single-stage configuration: 0x80 + 0x80, one-cycle latency
    check("s1_out_valid_idle", out_valid8, 1'b0);
    in_valid8 = 1'b1; a8 = 8'h80; b8 = 8'h80;
    #1;
    check("s1_in_ready", in_ready8, 1'b1);
    @(posedge clk);
    @(negedge clk);
    in_valid8 = 1'b0;
    check("s1_out_valid", out_valid8, 1'b1);
    check("s1_sum", sum8, 8'h00);
    check("s1_flags", {cout8, ovf8, zero8}, 3'b111);
    @(negedge clk);
    check("s1_drained", out_valid8, 1'b0);

    // 0xFFFF + 1: wraps to zero with carry, four-cycle latency
    step(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1);
    idle(3, 1'b1);
    check("d1_valid", out_valid, 1'b1);
    check("d1_sum", sum, 16'h0000);
    check("d1_flags", {cout, ovf, zero}, 3'b101);
    idle(1, 1'b1);

    // Signed overflow on add and on subtract
    step(1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1);
    step(1'b1, 16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1);
    idle(2, 1'b1);
    check("d2_sum", sum, 16'h8000);
    check("d2_flags", {cout, ovf, zero}, 3'b010);
    idle(1, 1'b1);
    check("d3_sum", sum, 16'h7FFF);
    check("d3_flags", {cout, ovf, zero}, 3'b110);
    idle(1, 1'b1);

    // Borrow cases
    step(1'b1, 16'h0005, 16'h0007, 1'b0, 1'b1, 1'b1);
    step(1'b1, 16'h0005, 16'h0005, 1'b1, 1'b1, 1'b1);
    idle(2, 1'b1);
    check("d4_sum", sum, 16'hFFFE);
    check("d4_flags", {cout, ovf, zero}, 3'b000);
    idle(1, 1'b1);
    check("d5_sum", sum, 16'hFFFF);
    check("d5_flags", {cout, ovf, zero}, 3'b000);
    idle(2, 1'b1);

    // Random stream with backpressure and occasional bubbles
    acc = 0;
    cyc = 0;
    while (acc < 200 && cyc < 5000) begin
      ordy = ($urandom_range(0, 3) != 0);
      iv   = ($urandom_range(0, 9) != 0);
      ra   = 16'($urandom);
      rb   = 16'($urandom);
      if (iv && !(pipe[ST-1].v && !ordy)) acc++;
      step(iv, ra, rb, 1'($urandom), 1'($urandom), ordy);
      cyc++;
    end
    check("rand_accepted", acc, 200);
    idle(ST + 2, 1'b1);

    // Reset with three ops in flight and the head stalled at the output
    step(1'b1, 16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h3333, 16'h0001, 1'b0, 1'b1, 1'b0);
    step(1'b1, 16'h4444, 16'h4444, 1'b1, 1'b0, 1'b0);
    idle(1, 1'b0);
    check("pre_rst_valid", out_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_sum", sum, 16'h0000);
    check("mid_rst_flags", {cout, ovf, zero}, 3'b000);
    check("mid_rst_in_ready", in_ready, 1'b1);
    clear_model();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 16'h1234, 16'h1111, 1'b0, 1'b0, 1'b1);
    idle(3, 1'b1);
    check("post_rst_valid", out_valid, 1'b1);
    check("post_rst_sum", sum, 16'h2345);
    idle(ST + 2, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
